// File: rtl/tiny_dnn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tiny_dnn_pkg                                                             |
// | Shared types and constants for the tiny_dnn AXI4-Lite control master.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package tiny_dnn_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RA   = 3'd3,
        RD   = 3'd4,
        RSP  = 3'd5
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // States in which the master is waiting on the slave.
    function automatic logic is_busy(input axil_state_t s);
        return (s == WR) || (s == WB) || (s == RA) || (s == RD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_dnn_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tiny_dnn_axil_master                                                     |
// | One-deep command port to single AXI4-Lite read/write transactions.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tiny_dnn_axil_master
    import tiny_dnn_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TO_CYC = 1024
) (
    input  logic              M_AXI_ACLK,
    input  logic              M_AXI_ARESETN,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,

    output logic              timeout,

    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [2:0]        M_AXI_AWPROT,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [31:0]       M_AXI_WDATA,
    output logic [3:0]        M_AXI_WSTRB,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [31:0]       M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);

    axil_state_t       r_state;
    axil_state_t       w_state_nxt;

    logic              w_awvalid_nxt;
    logic              w_wvalid_nxt;
    logic              w_bready_nxt;
    logic              w_arvalid_nxt;
    logic              w_rready_nxt;
    logic [ADDR_W-1:0] w_awaddr_nxt;
    logic [ADDR_W-1:0] w_araddr_nxt;
    logic [31:0]       w_wdata_nxt;
    logic [3:0]        w_wstrb_nxt;
    logic              w_rsp_valid_nxt;
    logic              w_rsp_write_nxt;
    logic [31:0]       w_rsp_rdata_nxt;
    logic [1:0]        w_rsp_resp_nxt;
    logic              w_aw_done;
    logic              w_w_done;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // A channel counts as done once its VALID has dropped or it handshakes now.
    assign w_aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_w_done  = !M_AXI_WVALID  || M_AXI_WREADY;

    always_comb begin
        w_state_nxt     = r_state;
        w_awvalid_nxt   = M_AXI_AWVALID;
        w_wvalid_nxt    = M_AXI_WVALID;
        w_bready_nxt    = M_AXI_BREADY;
        w_arvalid_nxt   = M_AXI_ARVALID;
        w_rready_nxt    = M_AXI_RREADY;
        w_awaddr_nxt    = M_AXI_AWADDR;
        w_araddr_nxt    = M_AXI_ARADDR;
        w_wdata_nxt     = M_AXI_WDATA;
        w_wstrb_nxt     = M_AXI_WSTRB;
        w_rsp_valid_nxt = rsp_valid;
        w_rsp_write_nxt = rsp_write;
        w_rsp_rdata_nxt = rsp_rdata;
        w_rsp_resp_nxt  = rsp_resp;

        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        w_state_nxt   = WR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_awaddr_nxt  = cmd_addr;
                        w_wdata_nxt   = cmd_wdata;
                        w_wstrb_nxt   = cmd_wstrb;
                    end else begin
                        w_state_nxt   = RA;
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = cmd_addr;
                    end
                end
            end
            WR: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    w_awvalid_nxt = 1'b0;
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_wvalid_nxt = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    w_state_nxt  = WB;
                    w_bready_nxt = 1'b1;
                end
            end
            WB: begin
                if (M_AXI_BVALID) begin
                    w_state_nxt     = RSP;
                    w_bready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b1;
                    w_rsp_rdata_nxt = 32'h0;
                    w_rsp_resp_nxt  = M_AXI_BRESP;
                end
            end
            RA: begin
                if (M_AXI_ARREADY) begin
                    w_state_nxt   = RD;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            RD: begin
                if (M_AXI_RVALID) begin
                    w_state_nxt     = RSP;
                    w_rready_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_write_nxt = 1'b0;
                    w_rsp_rdata_nxt = M_AXI_RDATA;
                    w_rsp_resp_nxt  = M_AXI_RRESP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // cmd_ready is registered from the next state so it stays low during reset.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= IDLE;
            cmd_ready     <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_WDATA   <= 32'h0;
            M_AXI_WSTRB   <= 4'h0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= 32'h0;
            rsp_resp      <= RESP_OKAY;
        end else begin
            r_state       <= w_state_nxt;
            cmd_ready     <= (w_state_nxt == IDLE);
            M_AXI_AWVALID <= w_awvalid_nxt;
            M_AXI_WVALID  <= w_wvalid_nxt;
            M_AXI_BREADY  <= w_bready_nxt;
            M_AXI_ARVALID <= w_arvalid_nxt;
            M_AXI_RREADY  <= w_rready_nxt;
            M_AXI_AWADDR  <= w_awaddr_nxt;
            M_AXI_ARADDR  <= w_araddr_nxt;
            M_AXI_WDATA   <= w_wdata_nxt;
            M_AXI_WSTRB   <= w_wstrb_nxt;
            rsp_valid     <= w_rsp_valid_nxt;
            rsp_write     <= w_rsp_write_nxt;
            rsp_rdata     <= w_rsp_rdata_nxt;
            rsp_resp      <= w_rsp_resp_nxt;
        end
    end

    generate
        if (TO_CYC > 0) begin : g_timeout
            localparam int              CNT_W  = $clog2(TO_CYC + 1);
            localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TO_CYC);

            logic [CNT_W-1:0] r_to_cnt;

            // Saturating watchdog; only flags, never aborts the transaction.
            always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
                if (!M_AXI_ARESETN) begin
                    r_to_cnt <= '0;
                    timeout  <= 1'b0;
                end else if ((r_state == IDLE) && (w_state_nxt != IDLE)) begin
                    r_to_cnt <= '0;
                end else if (is_busy(r_state) && (r_to_cnt != TO_MAX)) begin
                    r_to_cnt <= r_to_cnt + CNT_W'(1);
                    if (r_to_cnt == (TO_MAX - CNT_W'(1))) begin
                        timeout <= 1'b1;
                    end
                end
            end
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tiny_dnn_axil_master                                                  |
// | Directed bench with AXI-Lite slave model and response scoreboard.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_tiny_dnn_axil_master;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];

    tiny_dnn_axil_master #(.ADDR_W(32), .TO_CYC(8)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
        .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
        .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model with programmable per-channel delays
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic        ar_never = 1'b0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;
    logic [31:0] mem [0:15];
    int          b_beats, aw_hs_cyc, w_hs_cyc;

    assign awready = awvalid && (aw_cnt >= aw_dly);
    assign wready  = wvalid && (w_cnt >= w_dly);
    assign arready = arvalid && !ar_never && (ar_cnt >= ar_dly);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_a <= 0; w_d <= 0; w_s <= 0; ar_a <= 0;
            bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 0;
            aw_hs_cyc <= -1; w_hs_cyc <= -2;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; aw_a <= awaddr; aw_cnt <= 0; aw_hs_cyc <= cyc;
            end else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin
                w_got <= 1'b1; w_d <= wdata; w_s <= wstrb; w_cnt <= 0; w_hs_cyc <= cyc;
            end else if (wvalid) w_cnt <= w_cnt + 1;
            if (aw_got && w_got && !bvalid) begin
                if (b_cnt >= b_dly) begin
                    bvalid <= 1'b1; bresp <= bresp_val;
                    for (int i = 0; i < 4; i++)
                        if (w_s[i]) mem[aw_a[5:2]][8*i +: 8] <= w_d[8*i +: 8];
                end else b_cnt <= b_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1; ar_a <= araddr; ar_cnt <= 0;
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (ar_got && !rvalid) begin
                if (r_cnt >= r_dly) begin
                    rvalid <= 1'b1; rdata <= mem[ar_a[5:2]]; rresp <= rresp_val;
                end else r_cnt <= r_cnt + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0; r_cnt <= 0;
            end
        end
    end

    initial b_beats = 0;
    always @(posedge clk) if (rst_n && bvalid && bready) b_beats <= b_beats + 1;

    // VALID must hold, with stable payload, until its handshake
    logic        pend_aw, pend_w, pend_ar;
    logic [31:0] h_aw, h_w, h_ar;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_aw = 1'b0; pend_w = 1'b0; pend_ar = 1'b0;
        end else begin
            if (pend_aw) chk("aw_hold", {awvalid, awaddr[30:0]}, {1'b1, h_aw[30:0]});
            if (pend_w)  chk("w_hold",  {wvalid, wdata[30:0]},  {1'b1, h_w[30:0]});
            if (pend_ar) chk("ar_hold", {arvalid, araddr[30:0]}, {1'b1, h_ar[30:0]});
            pend_aw = awvalid && !awready; h_aw = awaddr;
            pend_w  = wvalid && !wready;   h_w  = wdata;
            pend_ar = arvalid && !arready; h_ar = araddr;
        end
    end

    // Scoreboard monitor: pops on every response handshake
    logic        hold_prev = 1'b0;
    exp_t        prev_rsp;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (hold_prev) chk("rsp_stable", {rsp_write, rsp_rdata[28:0], rsp_resp},
                               {prev_rsp.w, prev_rsp.d[28:0], prev_rsp.r});
            if (rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_write", {31'd0, rsp_write}, {31'd0, e.w});
                    chk("rsp_rdata", rsp_rdata, e.d);
                    chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.r});
                end
                hold_prev = 1'b0;
            end else begin
                hold_prev = 1'b1;
                prev_rsp  = '{w: rsp_write, d: rsp_rdata, r: rsp_resp};
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_valids"}, {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_addr", awaddr | araddr | wdata | {28'd0, wstrb}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic push, input exp_t e);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_accept_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (push) q.push_back(e);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1'b1;

        // Zero-wait write then read-back
        do_reset();
        issue(1'b1, 32'h04, 32'h3FF, 4'hF, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b00});
        wait_rsp(lat);
        chk("wr_latency", lat, 32'd3);
        drain();
        chk("aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
        issue(1'b0, 32'h04, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h3FF, r: 2'b00});
        wait_rsp(lat);
        chk("rd_latency", lat, 32'd3);
        drain();
        issue(1'b1, 32'h08, 32'h11223344, 4'h3, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b00});
        drain();
        issue(1'b0, 32'h08, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h00003344, r: 2'b00});
        drain();

        // W accepted 4 cycles before AW
        do_reset();
        aw_dly = 4;
        begin
            int b0;
            b0 = b_beats;
            issue(1'b1, 32'h20, 32'hA5A50001, 4'hF, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b00});
            @(posedge clk);
            @(negedge clk);
            chk("w_drop_first", {30'd0, awvalid, wvalid}, 32'd2);
            drain();
            chk("one_b_beat", b_beats - b0, 32'd1);
        end
        aw_dly = 0;
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'hA5A50001, r: 2'b00});
        drain();

        // Delayed R with back-pressured response
        do_reset();
        issue(1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b00});
        drain();
        r_dly = 5;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h3C, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'hCAFEF00D, r: 2'b00});
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("rd_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rsp_held", {30'd0, rsp_valid, cmd_ready}, 32'd2);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd1);
        r_dly = 0;
        drain();

        // Error responses pass through
        bresp_val = 2'b10;
        issue(1'b1, 32'h10, 32'h55, 4'hF, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b10});
        drain();
        bresp_val = 2'b00;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h55, r: 2'b00});
        drain();
        rresp_val = 2'b10;
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h55, r: 2'b10});
        drain();
        rresp_val = 2'b00;
        issue(1'b1, 32'h14, 32'h77, 4'hF, 1'b1, '{w: 1'b1, d: 32'h0, r: 2'b00});
        drain();

        // Reset asserted while waiting for B
        do_reset();
        b_dly = 4;
        issue(1'b1, 32'h18, 32'h99, 4'hF, 1'b0, '{w: 1'b1, d: 32'h0, r: 2'b00});
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bready && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reached_wb", {31'd0, bready}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        b_dly = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("release_plus1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        issue(1'b0, 32'h18, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h0, r: 2'b00});
        drain();

        // Watchdog with a slave that stalls AR
        do_reset();
        ar_never = 1'b1;
        issue(1'b0, 32'h00, 32'h0, 4'h0, 1'b1, '{w: 1'b0, d: 32'h0, r: 2'b00});
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("timeout_cyc%0d", k), {30'd0, timeout, arvalid},
                {30'd0, (k >= 8), 1'b1});
        end
        ar_never = 1'b0;
        drain();
        chk("timeout_sticky", {31'd0, timeout}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "global time limit");
    end

endmodule
`default_nettype wire
